// File: rtl/seq_shift_pkg.sv
// Shared constants and types for the multi-cycle shifter: shift modes and FSM state encoding.
package seq_shift_pkg;

  typedef logic [1:0] mode_t;

  localparam mode_t MODE_SLL = 2'b00;
  localparam mode_t MODE_SRL = 2'b01;
  localparam mode_t MODE_SRA = 2'b10;
  localparam mode_t MODE_ROL = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_SHIFT = 2'b01,
    ST_DONE  = 2'b10
  } state_e;

endpackage

// File: rtl/seq_shifter_shift_step.sv
// Combinational single-step shifter: shifts value by k (0..STEP) in one of four modes.
module shift_step
  import seq_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned K_W   = 1
) (
  input  logic [WIDTH-1:0] value,
  input  mode_t            mode,
  input  logic [K_W-1:0]   k,
  output logic [WIDTH-1:0] shifted_c
);

  logic [2*WIDTH-1:0] rot_c;

  // Rotation taken from the upper half of the doubled word shifted left.
  assign rot_c = {value, value} << k;

  always_comb begin
    shifted_c = value;
    case (mode)
      MODE_SLL: shifted_c = value << k;
      MODE_SRL: shifted_c = value >> k;
      MODE_SRA: shifted_c = WIDTH'($signed(value) >>> k);
      MODE_ROL: shifted_c = rot_c[2*WIDTH-1:WIDTH];
      default:  shifted_c = value;
    endcase
  end

endmodule

// File: rtl/seq_shifter.sv
// Multi-cycle shifter: accepts an operand on start/ready, shifts up to STEP bits per cycle,
// then holds the result and pulses done for one cycle.
module seq_shifter
  import seq_shift_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  parameter int unsigned SHAMT_W = $clog2(WIDTH),
  parameter int unsigned STEP    = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [1:0]         mode,
  input  logic [WIDTH-1:0]   data_in,
  input  logic [SHAMT_W-1:0] shamt,
  output logic               ready,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam int unsigned K_W = $clog2(STEP + 1);
  localparam logic [SHAMT_W-1:0] SHAMT_MAX = SHAMT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  mode_t              mode_q, mode_d;
  logic [WIDTH-1:0]   work_q, work_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [SHAMT_W-1:0] count_q, count_d;
  logic               ready_q, ready_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic [SHAMT_W-1:0] shamt_eff_c;
  logic [K_W-1:0]     k_c;
  logic [WIDTH-1:0]   step_out_c;

  // Amounts beyond the word (non power-of-two widths) saturate to WIDTH-1.
  assign shamt_eff_c = (shamt > SHAMT_MAX) ? SHAMT_MAX : shamt;

  always_comb begin
    if (32'(count_q) >= STEP) k_c = K_W'(STEP);
    else                      k_c = K_W'(count_q);
  end

  shift_step #(
    .WIDTH (WIDTH),
    .K_W   (K_W)
  ) u_shift_step (
    .value     (work_q),
    .mode      (mode_q),
    .k         (k_c),
    .shifted_c (step_out_c)
  );

  always_comb begin
    state_d  = state_q;
    mode_d   = mode_q;
    work_d   = work_q;
    result_d = result_q;
    count_d  = count_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          mode_d = mode;
          work_d = data_in;
          if (shamt_eff_c == '0) begin
            result_d = data_in;
            state_d  = ST_DONE;
          end else begin
            count_d = shamt_eff_c;
            state_d = ST_SHIFT;
          end
        end
      end
      ST_SHIFT: begin
        work_d  = step_out_c;
        count_d = count_q - SHAMT_W'(k_c);
        if (count_d == '0) begin
          result_d = step_out_c;
          state_d  = ST_DONE;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // Status flags are registered copies of the next state.
    ready_d = (state_d == ST_IDLE);
    busy_d  = (state_d != ST_IDLE);
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      mode_q   <= MODE_SLL;
      work_q   <= '0;
      result_q <= '0;
      count_q  <= '0;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      mode_q   <= mode_d;
      work_q   <= work_d;
      result_q <= result_d;
      count_q  <= count_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign ready  = ready_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule
